// File: rtl/button_cmd_sched_if.sv
// rtl/button_cmd_sched_if.sv - press/ack inputs and command/status outputs of the button command scheduler
interface button_cmd_sched_if;
    logic [3:0] press;
    logic       ack;
    logic       valid;
    logic [1:0] code;
    logic [3:0] pending;
    logic [7:0] drop_count;

    modport master (
        output press,
        output ack,
        input  valid,
        input  code,
        input  pending,
        input  drop_count
    );

    modport slave (
        input  press,
        input  ack,
        output valid,
        output code,
        output pending,
        output drop_count
    );
endinterface

// File: rtl/button_cmd_sched.sv
// rtl/button_cmd_sched.sv - round-robin scheduler turning button presses into acked commands with holdoff
module button_cmd_sched #(
    parameter int unsigned HOLDOFF = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    button_cmd_sched_if.slave  sched_io
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    // The IDLE grant cycle is itself one Valid=0 cycle, so HOLD covers the other HOLDOFF-1.
    localparam bit         SKIP_HOLD = (HOLDOFF <= 1);
    localparam logic [3:0] HOLD_LOAD = SKIP_HOLD ? 4'd0 : 4'(HOLDOFF - 1);

    state_e     state_q;
    logic       valid_q;
    logic [1:0] code_q;
    logic [1:0] last_q;
    logic [3:0] cnt_q;
    logic [3:0] pending_q;
    logic [3:0] pending_d;
    logic [7:0] drop_q;
    logic [7:0] drop_d;

    logic       grant_found;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic [3:0] clr_mask;
    logic [3:0] dropped;
    logic [2:0] drop_inc;
    logic [8:0] drop_sum;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_q;
        cand        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A press landing on the bit being granted re-arms it instead of counting as a drop.
    always_comb begin
        clr_mask  = (state_q == S_IDLE && grant_found) ? (4'b0001 << grant_idx) : 4'b0000;
        pending_d = (pending_q & ~clr_mask) | sched_io.press;
        dropped   = sched_io.press & pending_q & ~clr_mask;
        drop_inc  = 3'(dropped[0]) + 3'(dropped[1]) + 3'(dropped[2]) + 3'(dropped[3]);
        drop_sum  = {1'b0, drop_q} + 9'(drop_inc);
        drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            code_q    <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= 4'd0;
            pending_q <= 4'd0;
            drop_q    <= 8'd0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        state_q <= S_ISSUE;
                        valid_q <= 1'b1;
                        code_q  <= grant_idx;
                        last_q  <= grant_idx;
                    end
                end
                S_ISSUE: begin
                    if (sched_io.ack) begin
                        valid_q <= 1'b0;
                        if (SKIP_HOLD) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_HOLD;
                            cnt_q   <= HOLD_LOAD;
                        end
                    end
                end
                S_HOLD: begin
                    valid_q <= 1'b0;
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign sched_io.valid      = valid_q;
    assign sched_io.code       = code_q;
    assign sched_io.pending    = pending_q;
    assign sched_io.drop_count = drop_q;

endmodule

// File: tb/tb_button_cmd_sched.sv
// tb/tb_button_cmd_sched.sv - directed scoreboard bench for button_cmd_sched (HOLDOFF=4 and HOLDOFF=0)
module tb_button_cmd_sched;

    logic clk = 1'b0;
    logic rst4;
    logic rst0;

    always #5 clk = ~clk;

    button_cmd_sched_if if4 ();
    button_cmd_sched_if if0 ();

    button_cmd_sched #(.HOLDOFF(4)) dut4 (
        .clk_i    (clk),
        .rst_i    (rst4),
        .sched_io (if4)
    );

    button_cmd_sched #(.HOLDOFF(0)) dut0 (
        .clk_i    (clk),
        .rst_i    (rst0),
        .sched_io (if0)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [1:0] code);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk(tag, 32'(code), e);
    endtask

    task automatic wait_valid4(output int n);
        n = 0;
        while (if4.valid !== 1'b1 && n < 30) begin
            n++;
            tick();
        end
        if (n >= 30) chk("valid_timeout", 32'(if4.valid), 32'd1);
    endtask

    task automatic reset4();
        rst4      = 1'b1;
        if4.press = 4'b0000;
        if4.ack   = 1'b0;
        tick();
        tick();
        rst4 = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst0      = 1'b1;
        if0.press = 4'b0000;
        if0.ack   = 1'b0;

        // reset state
        reset4();
        chk("rst_valid", 32'(if4.valid), 32'd0);
        chk("rst_code", 32'(if4.code), 32'd0);
        chk("rst_pending", 32'(if4.pending), 32'd0);
        chk("rst_drop", 32'(if4.drop_count), 32'd0);

        // single press, ack withheld: valid two edges later, held stable
        if4.press = 4'b0001;
        exp_q.push_back(0);
        tick();
        if4.press = 4'b0000;
        chk("lat_pending_set", 32'(if4.pending), 32'b0001);
        chk("lat_not_yet_valid", 32'(if4.valid), 32'd0);
        tick();
        chk("lat_valid", 32'(if4.valid), 32'd1);
        pop_chk("lat_code", if4.code);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 32'(if4.valid), 32'd1);
            chk("hold_code", 32'(if4.code), 32'd0);
        end
        chk("hold_pending", 32'(if4.pending), 32'd0);

        // round robin over all four buttons with 4-cycle holdoff gaps
        reset4();
        if4.press = 4'b1111;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
        tick();
        if4.press = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_valid4(n);
            if (k > 0) chk("rr_gap", 32'(n), 32'd4);
            pop_chk("rr_code", if4.code);
            if4.ack = 1'b1;
            tick();
            if4.ack = 1'b0;
            chk("rr_ack_drops_valid", 32'(if4.valid), 32'd0);
        end

        // repeated presses on a pending button are counted as drops
        reset4();
        if4.press = 4'b0100;
        exp_q.push_back(2);
        tick();
        if4.press = 4'b0000;
        tick();
        chk("drop_valid", 32'(if4.valid), 32'd1);
        pop_chk("drop_code", if4.code);
        for (int r = 0; r < 3; r++) begin
            if4.press = 4'b0010;
            tick();
            if4.press = 4'b0000;
            tick();
        end
        chk("drop_pending", 32'(if4.pending), 32'b0010);
        chk("drop_count", 32'(if4.drop_count), 32'd2);
        chk("drop_still_code2", 32'(if4.code), 32'd2);
        exp_q.push_back(1);
        if4.ack = 1'b1;
        tick();
        if4.ack = 1'b0;
        wait_valid4(n);
        pop_chk("drop_next_code", if4.code);

        // press colliding with its own grant: set wins, no drop
        reset4();
        if4.press = 4'b0010;
        exp_q.push_back(1);
        tick();
        tick();
        if4.press = 4'b0000;
        chk("coll_valid", 32'(if4.valid), 32'd1);
        pop_chk("coll_code", if4.code);
        chk("coll_pending", 32'(if4.pending), 32'b0010);
        chk("coll_drop", 32'(if4.drop_count), 32'd0);
        exp_q.push_back(1);
        if4.ack = 1'b1;
        tick();
        if4.ack = 1'b0;
        wait_valid4(n);
        pop_chk("coll_reissue", if4.code);
        chk("coll_pending_clear", 32'(if4.pending), 32'd0);

        // reset during ISSUE overrides ack and press
        reset4();
        if4.press = 4'b0001;
        exp_q.push_back(0);
        tick();
        if4.press = 4'b0000;
        tick();
        pop_chk("abort_code", if4.code);
        if4.press = 4'b0100;
        tick();
        if4.press = 4'b0000;
        chk("abort_pending_pre", 32'(if4.pending), 32'b0100);
        rst4      = 1'b1;
        if4.ack   = 1'b1;
        if4.press = 4'b0010;
        tick();
        rst4      = 1'b0;
        if4.ack   = 1'b0;
        if4.press = 4'b0000;
        chk("abort_valid", 32'(if4.valid), 32'd0);
        chk("abort_pending", 32'(if4.pending), 32'd0);
        chk("abort_drop", 32'(if4.drop_count), 32'd0);
        chk("abort_code_rst", 32'(if4.code), 32'd0);
        tick();
        tick();
        chk("abort_idle", 32'(if4.valid), 32'd0);
        if4.press = 4'b0001;
        exp_q.push_back(0);
        tick();
        if4.press = 4'b0000;
        tick();
        chk("abort_restart_valid", 32'(if4.valid), 32'd1);
        pop_chk("abort_restart_code", if4.code);

        // drop counter saturates at 255
        reset4();
        if4.press = 4'b0001;
        tick();
        if4.press = 4'b0000;
        tick();
        if4.press = 4'b1111;
        tick();
        chk("sat_first", 32'(if4.drop_count), 32'd0);
        tick();
        chk("sat_step", 32'(if4.drop_count), 32'd4);
        repeat (78) tick();
        if4.press = 4'b0000;
        chk("sat_max", 32'(if4.drop_count), 32'd255);
        chk("sat_code", 32'(if4.code), 32'd0);

        // HOLDOFF=0, ack held high: one IDLE cycle between commands
        exp_q.delete();
        tick();
        rst0 = 1'b0;
        if0.press = 4'b0011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        tick();
        if0.press = 4'b0000;
        if0.ack   = 1'b1;
        chk("h0_pending", 32'(if0.pending), 32'b0011);
        chk("h0_valid0", 32'(if0.valid), 32'd0);
        tick();
        chk("h0_valid1", 32'(if0.valid), 32'd1);
        pop_chk("h0_code_a", if0.code);
        tick();
        chk("h0_gap", 32'(if0.valid), 32'd0);
        tick();
        chk("h0_valid2", 32'(if0.valid), 32'd1);
        pop_chk("h0_code_b", if0.code);
        tick();
        chk("h0_done", 32'(if0.valid), 32'd0);
        chk("h0_pending_clr", 32'(if0.pending), 32'd0);
        if0.ack = 1'b0;

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_cmd_sched.md
BUTTON_CMD_SCHED -- requirements
Module: button_cmd_sched

Interface
REQ-001 Parameter HOLDOFF, default 4, meaning: idle cycles enforced after each accepted command (legal range 0..15).
REQ-002 Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Press  input  4  one-clock button pulses, bit i = button i; multiple bits may be high in the same cycle.
REQ-005 Ack  input  1  consumer accepts the current command; sampled only while Valid=1.
REQ-006 Valid  output  1  a command is presented on Code.
REQ-007 Code  output  2  index of the button being issued.
REQ-008 Pending  output  4  registered per-button pending flags.
REQ-009 DropCount  output  8  saturating count of presses lost because the button was already pending.

Function
REQ-010 The block SHALL keep one pending flag per button; Press[i]=1 sets Pending[i] on the next edge.
REQ-011 If Press[i]=1 while Pending[i]=1 and Pending[i] is not being cleared in that cycle, DropCount SHALL increment by one per such bit, saturating at 255.
REQ-012 If the set and clear of Pending[i] occur in the same cycle, the set SHALL win and no drop is counted.
REQ-013 The FSM SHALL have states IDLE, ISSUE and HOLD; encoding is free, but an illegal state SHALL return to IDLE on the next edge.
REQ-014 In IDLE with Pending non-zero, the block SHALL grant round-robin: search upward from (Last+1) mod 4, grant the first set bit, load Code, clear that pending bit, and enter ISSUE.
REQ-015 Last SHALL be a 2-bit pointer updated to the granted index on every grant.
REQ-016 In IDLE with Pending zero, the state SHALL be unchanged, Valid=0 and Code held.
REQ-017 In ISSUE, Valid SHALL be 1 and Code SHALL be stable until Ack is sampled high.
REQ-018 In ISSUE with Ack=1, the next state SHALL be HOLD with the counter loaded to HOLDOFF-1, or IDLE directly if HOLDOFF=0.
REQ-019 In HOLD, Valid SHALL be 0 and the counter SHALL decrement each cycle; at count 0 the next state SHALL be IDLE, giving exactly HOLDOFF cycles with Valid=0.
REQ-020 Ack while Valid=0 SHALL be ignored.
REQ-021 Latency: a press at edge t on an idle, empty block SHALL produce Valid=1 at t+2.
REQ-022 Presses SHALL be captured in every state, including ISSUE and HOLD.
REQ-023 Valid, Code, Pending and DropCount SHALL be driven directly from registers.

Reset
REQ-024 On Reset=1 at a clock edge: state IDLE, Valid=0, Code=0, Pending=0, DropCount=0, Last=3 (so button 0 has first priority), counter=0.
REQ-025 Reset SHALL override all other inputs, including Press and Ack in the same cycle, and SHALL abort ISSUE or HOLD without completing the command.

Verification
REQ-026 After reset, Press=0001 for one cycle with Ack held 0 -> Valid=1, Code=0 two cycles later, held stable for 10 cycles; Pending=0000.
REQ-027 Press=1111 in one cycle, Ack pulsed on each Valid, HOLDOFF=4 -> Codes issued in order 0,1,2,3; each issue separated by exactly 4 cycles of Valid=0.
REQ-028 With Valid=1 on button 2 and Ack withheld, Press=0010 on three separate cycles -> Pending=0010 and DropCount=2.
REQ-029 Press[1] in the same cycle IDLE grants button 1 -> Pending[1]=1 after the edge, DropCount unchanged, and button 1 is issued again later.
REQ-030 Reset asserted during ISSUE with Pending=0100 and Ack=1 -> next cycle Valid=0, Pending=0000, DropCount=0, state IDLE.
REQ-031 HOLDOFF=0 with Pending=0011 and Ack held at 1 -> Valid stays low for one cycle between commands: Code=0, then a one-cycle IDLE gap, then Code=1.
